serial_adder_unit: RTL and testbench

- Bit-serial WIDTH-bit adder stage that wraps the existing 1-bit full-adder cell (datapath_adder).
- Captures two operands and a carry-in on a start handshake.
- Feeds one operand-bit pair plus the registered carry into the cell each clock, LSB first.
- Shifts the sum bits into a result register and reports the result with a one-cycle done pulse.

---
 rtl/serial_pkg.sv | 11 +
 rtl/datapath_adder.sv | 14 +
 rtl/serial_adder_unit.sv | 86 ++++++++
 tb/tb_serial_adder_unit.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// Shared constants for the bit-serial adder slice.
// State encoding and default operand width.
package serial_pkg;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam int DEF_WIDTH = 8;

endpackage

// File: rtl/datapath_adder.sv
// 1-bit full-adder cell, purely combinational.
// Used by the serial adder as its per-bit datapath.
module datapath_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder_unit.sv
// Bit-serial WIDTH-bit adder, LSB first, one bit per clock.
// Operands captured on start; done pulses for one cycle with the result.
module serial_adder_unit
  import serial_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             s_bit;
  logic             c_bit;
  logic             accept;

  datapath_adder u_cell (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry),
    .s    (s_bit),
    .cout (c_bit)
  );

  assign accept = start &
                  ((state == S_IDLE) | (state == S_DONE));

  assign busy = (state == S_SHIFT);
  assign done = (state == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      unique case (1'b1)
        accept: begin
          a_sh  <= a_in;
          b_sh  <= b_in;
          carry <= cin;
          cnt   <= '0;
          sum   <= '0;
          state <= S_SHIFT;
        end
        busy: begin
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          sum   <= {s_bit, sum[WIDTH-1:1]};
          carry <= c_bit;
          // counter parks at zero so it never passes WIDTH-1
          if (cnt == LAST) begin
            cnt   <= '0;
            cout  <= c_bit;
            state <= S_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_unit.sv
// Self-checking bench for serial_adder_unit at WIDTH=8 and WIDTH=16.
// Directed table, multi-cycle corner sequences, and random vs a+b+cin.
module tb_serial_adder_unit;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       ci;
    logic [7:0] s;
    logic       co;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        st8 = 1'b0;
  logic        st16 = 1'b0;
  logic [15:0] a_r = '0;
  logic [15:0] b_r = '0;
  logic        ci_r = 1'b0;

  logic        busy8, done8, co8;
  logic [7:0]  sum8;
  logic        busy16, done16, co16;
  logic [15:0] sum16;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  serial_adder_unit #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (st8),
    .a_in  (a_r[7:0]),
    .b_in  (b_r[7:0]),
    .cin   (ci_r),
    .busy  (busy8),
    .done  (done8),
    .sum   (sum8),
    .cout  (co8)
  );

  serial_adder_unit #(.WIDTH(16)) dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (st16),
    .a_in  (a_r),
    .b_in  (b_r),
    .cin   (ci_r),
    .busy  (busy16),
    .done  (done16),
    .sum   (sum16),
    .cout  (co16)
  );

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  // Watch dut8 for n cycles; report done count, first done cycle,
  // busy cycles, and the result captured on the first done.
  task automatic watch8(input int n, output int nd, output int first,
                        output int nb, output logic [7:0] s,
                        output logic co);
    nd = 0; first = -1; nb = 0; s = 'x; co = 1'bx;
    for (int k = 1; k <= n; k++) begin
      if (k > 1) @(negedge clk);
      if (busy8) nb++;
      if (done8) begin
        if (nd == 0) begin
          first = k; s = sum8; co = co8;
        end
        nd++;
      end
    end
  endtask

  task automatic run8(input string nm, input vec_t v);
    int nd, first, nb;
    logic [7:0] s;
    logic co;
    a_r = {8'h00, v.a}; b_r = {8'h00, v.b}; ci_r = v.ci; st8 = 1'b1;
    @(negedge clk);
    st8 = 1'b0;
    watch8(12, nd, first, nb, s, co);
    chk({nm, "_sum"}, 32'(s), 32'(v.s));
    chk({nm, "_cout"}, 32'(co), 32'(v.co));
    chk({nm, "_done_cycle"}, first, 9);
    chk({nm, "_busy_cycles"}, nb, 8);
    chk({nm, "_done_count"}, nd, 1);
    chk({nm, "_held_sum"}, 32'({co8, sum8}), 32'({v.co, v.s}));
  endtask

  initial begin
    vec_t tbl[6];
    int nd, first, nb, dc[$];
    logic [7:0] s;
    logic co;
    logic [16:0] exp16;
    logic [8:0] exp8;
    bit got8, got16;

    tbl[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0};
    tbl[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    tbl[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    tbl[3] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
    tbl[4] = '{8'h80, 8'h7F, 1'b1, 8'h00, 1'b1};
    tbl[5] = '{8'h03, 8'h04, 1'b0, 8'h07, 1'b0};

    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy8), 0);
    chk("rst_done", 32'(done8), 0);
    chk("rst_sum", 32'(sum8), 0);
    chk("rst_cout", 32'(co8), 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++)
      run8($sformatf("tbl%0d", i), tbl[i]);

    // start while busy is ignored, input changes have no effect
    a_r = 16'h10; b_r = 16'h20; ci_r = 1'b0; st8 = 1'b1;
    @(negedge clk);
    st8 = 1'b0;
    nd = 0; first = -1; s = 'x; co = 1'bx;
    for (int k = 1; k <= 14; k++) begin
      if (k > 1) @(negedge clk);
      if (k == 3) begin
        a_r = 16'hAA; b_r = 16'h55; ci_r = 1'b1; st8 = 1'b1;
      end
      if (k == 4) st8 = 1'b0;
      if (done8) begin
        if (nd == 0) begin first = k; s = sum8; co = co8; end
        nd++;
      end
    end
    chk("ign_sum", 32'(s), 32'h30);
    chk("ign_cout", 32'(co), 0);
    chk("ign_done_count", nd, 1);
    chk("ign_done_cycle", first, 9);

    // reset asserted mid-shift aborts cleanly
    a_r = 16'h7F; b_r = 16'h01; ci_r = 1'b0; st8 = 1'b1;
    @(negedge clk);
    st8 = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy8), 0);
    chk("abort_done", 32'(done8), 0);
    chk("abort_sum", 32'(sum8), 0);
    chk("abort_cout", 32'(co8), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    watch8(12, nd, first, nb, s, co);
    chk("abort_no_done", nd, 0);
    chk("abort_no_busy", nb, 0);
    chk("abort_sum_after", 32'(sum8), 0);
    run8("after_abort", tbl[5]);

    // back-to-back: start held, new operands presented in DONE
    a_r = 16'h01; b_r = 16'h02; ci_r = 1'b0; st8 = 1'b1;
    dc = {};
    for (int k = 1; k <= 22; k++) begin
      @(negedge clk);
      if (done8) begin
        dc.push_back(k);
        if (dc.size() == 1) begin
          chk("b2b_sum0", 32'(sum8), 32'h03);
          chk("b2b_cout0", 32'(co8), 0);
          a_r = 16'h80; b_r = 16'h80;
        end else begin
          chk("b2b_sum1", 32'(sum8), 32'h00);
          chk("b2b_cout1", 32'(co8), 1);
        end
      end
      if (k == 10) st8 = 1'b0;
    end
    chk("b2b_done_count", dc.size(), 2);
    if (dc.size() == 2) begin
      chk("b2b_done_at0", dc[0], 9);
      chk("b2b_done_at1", dc[1], 18);
    end
    repeat (2) @(negedge clk);

    // random, both widths in parallel against plain addition
    for (int i = 0; i < 1000; i++) begin
      a_r = 16'($urandom);
      b_r = 16'($urandom);
      ci_r = 1'($urandom);
      exp8 = 9'(a_r[7:0]) + 9'(b_r[7:0]) + 9'(ci_r);
      exp16 = 17'(a_r) + 17'(b_r) + 17'(ci_r);
      st8 = 1'b1; st16 = 1'b1;
      @(negedge clk);
      st8 = 1'b0; st16 = 1'b0;
      got8 = 1'b0; got16 = 1'b0;
      for (int k = 1; k <= 40 && !got16; k++) begin
        if (k > 1) @(negedge clk);
        if (done8 && !got8) begin
          got8 = 1'b1;
          chk("rnd8", 32'({co8, sum8}), 32'(exp8));
        end
        if (done16) begin
          got16 = 1'b1;
          chk("rnd16", 32'({co16, sum16}), 32'(exp16));
        end
      end
      if (!got8) chk("rnd8_timeout", 0, 1);
      if (!got16) chk("rnd16_timeout", 0, 1);
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
